// File: rtl/rec_pkg.sv
// rtl/rec_pkg.sv - record type, width, FSM states and parity helper for the record serial link
package rec_pkg;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] payload;
        logic        flag;
        bit          en;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } rec_state_e;

    // Parity bit that makes the total count of ones over record plus parity even.
    function automatic logic even_par(rec_t r);
        return ^r;
    endfunction

endpackage

// File: rtl/rec_deser_if.sv
// rtl/rec_deser_if.sv - serial input and record output bundle of the record deserializer
interface rec_deser_if;

    logic            ser_in;
    logic            ser_vld;
    logic            ser_sof;
    rec_pkg::rec_t   rec_data;
    logic            rec_valid;
    logic            rec_ready;
    logic            parity_err;
    logic            frame_err;
    logic            overrun;

    // Upstream transmitter plus downstream consumer view.
    modport master (
        output ser_in, ser_vld, ser_sof, rec_ready,
        input  rec_data, rec_valid, parity_err, frame_err, overrun
    );

    // Deserializer view.
    modport slave (
        input  ser_in, ser_vld, ser_sof, rec_ready,
        output rec_data, rec_valid, parity_err, frame_err, overrun
    );

endinterface

// File: rtl/rec_deser.sv
// rtl/rec_deser.sv - serial-to-parallel record receiver with even parity check and one-entry hold
module rec_deser
    import rec_pkg::*;
#(
    parameter int REC_W = $bits(rec_t)
) (
    input  logic        clk,
    input  logic        rst_n,
    rec_deser_if.slave  bus
);

    localparam int CNT_W = $clog2(REC_W + 1);

    rec_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REC_W-1:0] shreg_q, shreg_d;
    rec_t             rec_data_q, rec_data_d;
    logic             rec_valid_q, rec_valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             is_last;
    logic             par_ok;

    assign is_last = (bit_cnt_q == CNT_W'(REC_W - 1));
    assign par_ok  = (even_par(rec_t'(shreg_q)) == bus.ser_in);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: an SOF always restarts a frame, otherwise walk data bits then parity.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ser_vld && bus.ser_sof) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.ser_vld) begin
                    if (bus.ser_sof)  state_d = ST_SHIFT;
                    else if (is_last) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (bus.ser_vld) state_d = bus.ser_sof ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and pulse next values; the held record drains on ready and may be refilled on the same edge.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rec_data_d  = rec_data_q;
        rec_valid_d = rec_valid_q && !bus.rec_ready;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;
        if (bus.ser_vld) begin
            if (bus.ser_sof) begin
                shreg_d   = REC_W'(bus.ser_in);
                bit_cnt_d = CNT_W'(1);
                ferr_d    = (state_q != ST_IDLE);
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        shreg_d   = {shreg_q[REC_W-2:0], bus.ser_in};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    ST_PARITY: begin
                        bit_cnt_d = '0;
                        if (!par_ok) begin
                            perr_d = 1'b1;
                        end else if (!rec_valid_q || bus.rec_ready) begin
                            rec_data_d  = rec_t'(shreg_q);
                            rec_valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rec_data_q  <= '0;
            rec_valid_q <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rec_data_q  <= rec_data_d;
            rec_valid_q <= rec_valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.rec_data   = rec_data_q;
    assign bus.rec_valid  = rec_valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_rec_deser.sv
// tb/tb_rec_deser.sv - randomized and directed self-checking bench for rec_deser
module tb_rec_deser;
    import rec_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rec_deser_if bus ();

    rec_deser #(.REC_W(REC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    bit   exp_valid, exp_perr, exp_ferr, exp_ovr;
    rec_t exp_data;
    bit   frame_q[$];

    int   dut_hs = 0;
    rec_t last_hs_data;

    rec_t r1, r2;

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle compare against the model, plus DUT handshake capture.
    always @(negedge clk) begin
        if (chk_en) begin
            check1("rec_valid",  32'(bus.rec_valid),  32'(exp_valid));
            check1("rec_data",   32'(bus.rec_data),   32'(exp_data));
            check1("parity_err", 32'(bus.parity_err), 32'(exp_perr));
            check1("frame_err",  32'(bus.frame_err),  32'(exp_ferr));
            check1("overrun",    32'(bus.overrun),    32'(exp_ovr));
            if (bus.rec_valid === 1'b1 && bus.rec_ready === 1'b1) begin
                dut_hs++;
                last_hs_data = bus.rec_data;
            end
        end
    end

    // Behavioural model: collect frame bits in a queue, judge whole frames by counting ones.
    task automatic model_step();
        bit   new_valid;
        int   ones;
        rec_t d;
        if (!rst_n) begin
            exp_valid = 0; exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
            exp_data  = '0;
            frame_q.delete();
            return;
        end
        exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
        new_valid = exp_valid && !bus.rec_ready;
        if (bus.ser_vld) begin
            if (bus.ser_sof) begin
                if (frame_q.size() > 0) exp_ferr = 1;
                frame_q.delete();
                frame_q.push_back(bus.ser_in);
            end else if (frame_q.size() > 0) begin
                frame_q.push_back(bus.ser_in);
                if (frame_q.size() == REC_W + 1) begin
                    ones = 0;
                    foreach (frame_q[i]) ones += int'(frame_q[i]);
                    for (int i = 0; i < REC_W; i++) d[REC_W-1-i] = frame_q[i];
                    if (ones % 2 != 0)                   exp_perr = 1;
                    else if (!exp_valid || bus.rec_ready) begin
                        exp_data  = d;
                        new_valid = 1;
                    end else                             exp_ovr = 1;
                    frame_q.delete();
                end
            end
        end
        exp_valid = new_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit vld, input bit sof, input bit b);
        bus.ser_vld = vld;
        bus.ser_sof = sof;
        bus.ser_in  = b;
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input rec_t d, input bit p);
        for (int i = 0; i < REC_W; i++) drive(1'b1, i == 0, d[REC_W-1-i]);
        drive(1'b1, 1'b0, p);
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_valid"}, 32'(bus.rec_valid),  32'd0);
        check1({tag, "_data"},  32'(bus.rec_data),   32'd0);
        check1({tag, "_perr"},  32'(bus.parity_err), 32'd0);
        check1({tag, "_ferr"},  32'(bus.frame_err),  32'd0);
        check1({tag, "_ovr"},   32'(bus.overrun),    32'd0);
    endtask

    initial begin
        int hs0;
        logic [REC_W-1:0] rnd;
        rec_t d;
        bit   p;
        int   len;

        r1 = '{tag: 8'hA5, payload: 16'h1234, flag: 1'b1, en: 1'b1};
        r2 = '{tag: 8'h3C, payload: 16'h00FF, flag: 1'b0, en: 1'b1};
        bus.ser_vld = 0; bus.ser_sof = 0; bus.ser_in = 0; bus.rec_ready = 0;

        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Clean frame.
        bus.rec_ready = 1;
        send_frame(r1, 1'b1);
        check1("clean_valid", 32'(bus.rec_valid),  32'd1);
        check1("clean_data",  32'(bus.rec_data),   32'h29448D3);
        check1("clean_perr",  32'(bus.parity_err), 32'd0);
        idle();
        check1("clean_drop",  32'(bus.rec_valid),  32'd0);

        // Bad parity.
        send_frame(r1, 1'b0);
        check1("badpar_perr",  32'(bus.parity_err), 32'd1);
        check1("badpar_valid", 32'(bus.rec_valid),  32'd0);
        idle();
        check1("badpar_pulse", 32'(bus.parity_err), 32'd0);

        // Stall and overrun.
        bus.rec_ready = 0;
        send_frame(r1, 1'b1);
        idle();
        idle();
        send_frame(r2, 1'b1);
        check1("ovr_pulse", 32'(bus.overrun),   32'd1);
        check1("ovr_hold",  32'(bus.rec_data),  32'h29448D3);
        check1("ovr_valid", 32'(bus.rec_valid), 32'd1);
        idle();
        hs0 = dut_hs;
        bus.rec_ready = 1;
        idle();
        idle();
        idle();
        check1("ovr_hs_count", 32'(dut_hs - hs0), 32'd1);
        check1("ovr_hs_data",  32'(last_hs_data), 32'h29448D3);

        // Same-edge replace.
        bus.rec_ready = 0;
        send_frame(r1, 1'b1);
        idle();
        for (int i = 0; i < REC_W; i++) drive(1'b1, i == 0, r2[REC_W-1-i]);
        bus.rec_ready = 1;
        drive(1'b1, 1'b0, 1'b1);
        check1("repl_valid", 32'(bus.rec_valid), 32'd1);
        check1("repl_data",  32'(bus.rec_data),  32'hF003FD);
        check1("repl_ovr",   32'(bus.overrun),   32'd0);
        idle();

        // Early SOF at bit 10.
        for (int i = 0; i < 10; i++) drive(1'b1, i == 0, r1[REC_W-1-i]);
        drive(1'b1, 1'b1, r2[REC_W-1]);
        check1("esof_ferr", 32'(bus.frame_err), 32'd1);
        for (int i = 1; i < REC_W; i++) drive(1'b1, 1'b0, r2[REC_W-1-i]);
        drive(1'b1, 1'b0, 1'b1);
        check1("esof_valid", 32'(bus.rec_valid), 32'd1);
        check1("esof_data",  32'(bus.rec_data),  32'hF003FD);
        idle();

        // Reset mid-frame.
        for (int i = 0; i < 15; i++) drive(1'b1, i == 0, r1[REC_W-1-i]);
        bus.ser_vld = 0;
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        rst_n = 1'b1;
        idle();
        send_frame(r1, 1'b1);
        check1("postrst_valid", 32'(bus.rec_valid), 32'd1);
        check1("postrst_data",  32'(bus.rec_data),  32'h29448D3);

        // Randomized traffic: gaps, stray bits, truncated frames, bad parity, ready stalls, resets.
        for (int f = 0; f < 200; f++) begin
            int ready_bias;
            ready_bias = $urandom_range(0, 3);
            rnd = REC_W'($urandom);
            d   = rnd;
            p   = even_par(d) ^ ($urandom_range(0, 7) == 0);
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, REC_W) : REC_W + 1;
            if ($urandom_range(0, 5) == 0) begin
                bus.rec_ready = 1'($urandom_range(0, 1));
                drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    bus.rec_ready = ($urandom_range(0, 3) < ready_bias);
                    idle();
                end
                bus.rec_ready = ($urandom_range(0, 3) < ready_bias);
                if (i < REC_W) drive(1'b1, i == 0, d[REC_W-1-i]);
                else           drive(1'b1, 1'b0, p);
            end
            if ($urandom_range(0, 39) == 0) begin
                bus.ser_vld = 0;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        bus.rec_ready = 1;
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
